// File: rtl/zybo_input_conditioner_pkg.sv
// Shared constants for the ZYBO input conditioner: button indices, step FSM
// encoding and the default debounce length.
package zybo_input_conditioner_pkg;

  localparam int BTN_RUN  = 1;
  localparam int BTN_HALT = 2;
  localparam int BTN_STEP = 3;

  // 2 ms at 125 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 250000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/zybo_input_conditioner_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a consecutive-mismatch counter
// that only moves the stable level after DEBOUNCE_CYCLES agreeing samples.
module zybo_input_conditioner_debounce_bit
  import zybo_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_st
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_st;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_st    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // any sample agreeing with the stable level restarts the count
      if (r_sync2 != r_st) begin
        if (r_cnt == CNT_LAST) begin
          r_st  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_st = r_st;

endmodule

// File: rtl/zybo_input_conditioner.sv
// Debounces the ZYBO buttons/switches and turns button presses into run/halt
// pulses and a 4-phase step_cycle/step_ack handshake toward the core.
module zybo_input_conditioner
  import zybo_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:1] buttons_raw,
  input  logic [1:0] switches_raw,
  output logic [3:1] zybo_buttons,
  output logic [1:0] zybo_switches,
  output logic       dbg_run_core,
  output logic       dbg_halt_core,
  output logic       step_cycle,
  input  logic       step_ack,
  output logic       step_busy,
  output logic [3:0] step_drops
);

  logic [4:0] w_raw;
  logic [4:0] w_st;
  logic [3:1] w_btn;
  logic [3:1] w_rise;
  logic       w_press;
  logic       w_drop;
  logic [1:0] w_next_state;

  logic [3:1] r_btn_prev;
  logic       r_ack_s1;
  logic       r_ack_s2;
  logic [1:0] r_state;
  logic [3:0] r_drops;
  logic       r_run;
  logic       r_halt;

  assign w_raw = {buttons_raw, switches_raw};

  for (genvar g = 0; g < 5; g++) begin : g_db
    zybo_input_conditioner_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .i_raw(w_raw[g]),
      .o_st (w_st[g])
    );
  end

  assign w_btn   = w_st[4:2];
  assign w_rise  = w_btn & ~r_btn_prev;
  assign w_press = w_rise[BTN_STEP];

  always_comb begin
    w_next_state = r_state;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          if (r_ack_s2) w_drop = 1'b1;
          else          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        w_drop = w_press;
        if (r_ack_s2) w_next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_drop = w_press;
        if (!r_ack_s2) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= '0;
      r_ack_s1   <= 1'b0;
      r_ack_s2   <= 1'b0;
      r_state    <= ST_IDLE;
      r_drops    <= '0;
      r_run      <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_btn_prev <= w_btn;
      r_ack_s1   <= step_ack;
      r_ack_s2   <= r_ack_s1;
      r_state    <= w_next_state;
      // halt takes priority when both buttons are accepted together
      r_halt     <= w_rise[BTN_HALT];
      r_run      <= w_rise[BTN_RUN] & ~w_rise[BTN_HALT];
      if (w_drop) r_drops <= sat_inc4(r_drops);
    end
  end

  assign zybo_buttons  = w_btn;
  assign zybo_switches = w_st[1:0];
  assign dbg_run_core  = r_run;
  assign dbg_halt_core = r_halt;
  assign step_cycle    = (r_state == ST_REQ);
  assign step_busy     = (r_state != ST_IDLE);
  assign step_drops    = r_drops;

endmodule

// File: tb/tb_zybo_input_conditioner.sv
// Scoreboard bench for zybo_input_conditioner with a window-based reference model.
module tb_zybo_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:1] buttons_raw = '0;
  logic [1:0] switches_raw = '0;
  logic       step_ack = 1'b0;
  logic [3:1] zybo_buttons;
  logic [1:0] zybo_switches;
  logic       dbg_run_core, dbg_halt_core, step_cycle, step_busy;
  logic [3:0] step_drops;

  always #5 clk = ~clk;

  zybo_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons_raw  (buttons_raw),
    .switches_raw (switches_raw),
    .zybo_buttons (zybo_buttons),
    .zybo_switches(zybo_switches),
    .dbg_run_core (dbg_run_core),
    .dbg_halt_core(dbg_halt_core),
    .step_cycle   (step_cycle),
    .step_ack     (step_ack),
    .step_busy    (step_busy),
    .step_drops   (step_drops)
  );

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] pk(input logic [2:0] b, input logic [1:0] s,
                                     input logic r, input logic h, input logic c,
                                     input logic y, input logic [3:0] d);
    return {b, s, r, h, c, y, d};
  endfunction

  function automatic logic [12:0] dut_vec();
    return pk(zybo_buttons, zybo_switches, dbg_run_core, dbg_halt_core,
              step_cycle, step_busy, step_drops);
  endfunction

  // Reference model: history of raw samples per edge {ack, btn3..1, sw1..0}
  logic [5:0] hist[$];
  logic [4:0] m_st, m_stp;
  logic       m_run, m_halt;
  int         m_phase;  // 0 idle, 1 request, 2 release
  logic [3:0] m_drops;

  task automatic model_reset();
    hist.delete();
    repeat (D + 2) hist.push_back(6'd0);
    m_st = '0; m_stp = '0; m_run = 0; m_halt = 0; m_phase = 0; m_drops = '0;
  endtask

  task automatic model_edge();
    logic [4:0] rise, nst;
    logic acks, press, drop, all_diff;
    int n;
    hist.push_back({step_ack, buttons_raw, switches_raw});
    if (hist.size() > 32) void'(hist.pop_front());
    n = hist.size();
    rise   = m_st & ~m_stp;
    m_halt = rise[3];
    m_run  = rise[2] & ~rise[3];
    press  = rise[4];
    acks   = hist[n-3][5];
    drop   = 1'b0;
    case (m_phase)
      0: if (press) begin if (acks) drop = 1'b1; else m_phase = 1; end
      1: begin drop = press; if (acks) m_phase = 2; end
      default: begin drop = press; if (!acks) m_phase = 0; end
    endcase
    if (drop && m_drops != 4'hF) m_drops = m_drops + 4'd1;
    // a level is accepted once the samples 2..D+1 edges back all disagree with it
    nst = m_st;
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[n-1-k][b] == m_st[b]) all_diff = 1'b0;
      if (all_diff) nst[b] = ~m_st[b];
    end
    m_stp = m_st;
    m_st  = nst;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_edge();
    exp_q.push_back(pk(m_st[4:2], m_st[1:0], m_run, m_halt, m_phase == 1,
                       m_phase != 0, m_drops));
  end

  // Monitor: compare each cycle's outputs against the scoreboard entry
  always @(negedge clk) begin
    logic [12:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b expected=%b (btn,sw,run,halt,cyc,busy,drops)",
                 $time, a, e);
      end
    end
  end

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out(input string nm, input bit use_busy, input logic val, input int budget);
    int c;
    c = 0;
    while (((use_busy ? step_busy : step_cycle) !== val) && c < budget) begin
      tick(1);
      c++;
    end
    checks++;
    if ((use_busy ? step_busy : step_cycle) !== val) begin
      errors++;
      $display("FAIL %s timeout got=%b expected=%b", nm,
               use_busy ? step_busy : step_cycle, val);
    end
  endtask

  task automatic press_release(input int hold);
    buttons_raw[3] = 1'b1; tick(hold);
    buttons_raw[3] = 1'b0; tick(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("reset_state", dut_vec(), 13'd0);
    rst_n = 1'b1;

    // btn1 glitches then held: only the held level passes, one run pulse
    buttons_raw[1] = 1; tick(1);
    buttons_raw[1] = 0; tick(1);
    buttons_raw[1] = 1; tick(12);
    buttons_raw[1] = 0; tick(10);

    // short switch blip must never reach the outputs
    switches_raw = 2'b01; tick(3);
    switches_raw = 2'b00; tick(10);

    // run and halt together: halt wins
    buttons_raw[2:1] = 2'b11; tick(12);
    buttons_raw[2:1] = 2'b00; tick(10);

    // full step handshake
    buttons_raw[3] = 1;
    wait_out("step_cycle_rise", 1'b0, 1'b1, 30);
    tick(5); step_ack = 1;
    tick(3); step_ack = 0;
    wait_out("step_busy_fall", 1'b1, 1'b0, 30);
    buttons_raw[3] = 0; tick(10);
    check("drops_after_handshake", {9'd0, step_drops}, 13'd0);

    // presses while the handshake is busy are dropped
    buttons_raw[3] = 1;
    wait_out("step_cycle_rise2", 1'b0, 1'b1, 30);
    step_ack = 1; tick(2);
    buttons_raw[3] = 0; tick(7);
    repeat (3) press_release(7);
    step_ack = 0;
    wait_out("step_busy_fall2", 1'b1, 1'b0, 30);
    tick(4);
    check("drops_three", {9'd0, step_drops}, 13'd3);

    // ack stuck high: presses dropped in IDLE, count saturates
    step_ack = 1; tick(4);
    repeat (20) press_release(7);
    check("drops_saturate", {9'd0, step_drops}, 13'd15);
    step_ack = 0; tick(10);

    // reset mid-request
    rst_n = 0; tick(2); rst_n = 1; tick(2);
    buttons_raw[3] = 1;
    wait_out("step_cycle_rise3", 1'b0, 1'b1, 30);
    #2 rst_n = 0;
    #1 check("async_reset_outputs", dut_vec(), 13'd0);
    buttons_raw[3] = 0;
    tick(3);
    rst_n = 1;
    step_ack = 1; tick(6);
    check("no_step_after_reset", {12'd0, step_cycle}, 13'd0);
    step_ack = 0; tick(8);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int b = 1; b <= 3; b++)
        if ($urandom_range(0, 5) == 0) buttons_raw[b] = ~buttons_raw[b];
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) switches_raw[b] = ~switches_raw[b];
      if ($urandom_range(0, 7) == 0) step_ack = ~step_ack;
      if (i == 400) rst_n = 0;
      if (i == 403) rst_n = 1;
      tick(1);
    end

    buttons_raw = '0; switches_raw = '0; step_ack = 0;
    tick(3);
    #1 check("scoreboard_drained", 13'(exp_q.size()), 13'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zybo_input_conditioner.md
Name: zybo_input_conditioner

Overview:
- Front-end conditioner between the raw ZYBO push-buttons/switches and the cpu run-control inputs.
- Synchronises and debounces all buttons and switches.
- Converts button presses into one-cycle dbg_run_core / dbg_halt_core pulses.
- Drives the 4-phase step_cycle/step_ack handshake that the core expects for single-cycle stepping.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new input level (2 ms at 125 MHz); legal range 1..2^20.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic single clock domain
- rst_n  input  1  asynchronous, active-low reset
- buttons_raw  input  3 [3:1]  raw, bouncing ZYBO buttons; 1=run, 2=halt, 3=step
- switches_raw  input  2 [1:0]  raw ZYBO switches
- zybo_buttons  output  3 [3:1]  debounced button levels
- zybo_switches  output  2 [1:0]  debounced switch levels
- dbg_run_core  output  1  one-cycle run pulse
- dbg_halt_core  output  1  one-cycle halt pulse
- step_cycle  output  1  step request level, 4-phase handshake
- step_ack  input  1  step acknowledge from core
- step_busy  output  1  step handshake in progress
- step_drops  output  4  saturating count of step presses dropped

Behaviour:
- Reset (rst_n=0, async): all outputs 0; synchronisers, counters, stable levels and FSM cleared; step FSM goes to IDLE.
- Synchroniser: 2 flip-flop stages on every raw input and on step_ack.
- Debounce, per bit:
  - Counter cnt, stable level st.
  - If sync != st: cnt increments; when cnt == DEBOUNCE_CYCLES-1 with mismatch still present, st <= sync and cnt <= 0.
  - If sync == st: cnt <= 0.
  - Latency: st changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples the new raw level.
  - Any glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches st.
- Debounced outputs: zybo_buttons and zybo_switches equal st directly; no extra register.
- Run/halt pulses:
  - Registered rising-edge detect on st; the pulse is high in the cycle after st goes 0->1, for exactly 1 cycle.
  - Falling edges produce nothing.
  - If run and halt rise in the same cycle, halt wins and run is suppressed.
- Step FSM (btn3 rising edge = press):
  - IDLE: step_cycle=0, step_busy=0. On press with synced step_ack==0, go to REQ. On press with synced step_ack==1, stay in IDLE and count a drop.
  - REQ: step_cycle=1, step_busy=1. Leave when synced step_ack==1, go to RELEASE.
  - RELEASE: step_cycle=0, step_busy=1. Leave when synced step_ack==0, go to IDLE.
  - Presses in REQ or RELEASE are dropped and counted.
  - step_drops saturates at 15; it is cleared only by reset.
- Simultaneous events:
  - A step press is independent of run/halt; all may fire in the same cycle.
  - A step press in the same cycle RELEASE->IDLE occurs is dropped.
- Reset mid-handshake: step_cycle drops immediately (async); the FSM returns to IDLE; the core's later step_ack is ignored until the next press.

Decomposition:
- Shared package holds:
  - Button index constants: BTN_RUN=1, BTN_HALT=2, BTN_STEP=3.
  - Step FSM state encoding: IDLE=2'd0, REQ=2'd1, RELEASE=2'd2.
  - Default DEBOUNCE_CYCLES.
- One sub-module, debounce_bit: synchroniser + counter + stable level, parameterised by DEBOUNCE_CYCLES and CNT_W.
  - Instantiated 5 times, once per button and switch bit.
  - step_ack uses a plain 2-FF synchroniser.

Test Plan (DEBOUNCE_CYCLES=4 for all):
- buttons_raw[1] toggled 1/0/1 at 1-cycle spacing, then held 1 -> zybo_buttons[1] rises exactly on the 6th edge after the final rise; dbg_run_core high for exactly 1 cycle; no pulse from the glitches.
- switches_raw=2'b01 held 3 cycles, then back to 0 -> zybo_switches stays 2'b00 throughout.
- buttons_raw[2] and buttons_raw[1] rising on the same edge, held -> dbg_halt_core pulses once; dbg_run_core stays 0.
- btn3 press, step_ack raised 5 cycles after step_cycle rises, lowered 3 cycles later:
  - step_cycle falls 3 edges after step_ack rises.
  - step_busy falls 3 edges after step_ack falls.
  - step_drops=0.
- Three btn3 presses while step_ack held 1 in REQ -> step_drops=3; one step handshake total. Then 20 presses with step_ack stuck 1 -> step_drops saturates at 15.
- rst_n pulsed low while in REQ -> step_cycle=0 with no clock edge; FSM in IDLE; all outputs 0; the subsequent step_ack rise/fall produces no step_cycle.
